// File: rtl/lbm_pkg.sv
// Shared D2Q9 constants, saturation helper and FSM state type for the moment/divider stage.
package lbm_pkg;

   localparam int unsigned DirRest = 0;
   localparam int unsigned DirE    = 1;
   localparam int unsigned DirN    = 2;
   localparam int unsigned DirW    = 3;
   localparam int unsigned DirS    = 4;
   localparam int unsigned DirNe   = 5;
   localparam int unsigned DirNw   = 6;
   localparam int unsigned DirSw   = 7;
   localparam int unsigned DirSe   = 8;
   localparam int unsigned NumDirs = 9;

   typedef enum logic [2:0] {
      StIdle,
      StSum,
      StXs,
      StXw,
      StYs,
      StYw,
      StOut
   } lbm_state_e;

   // Clamp a sign-extended value into the signed range of a w-bit word (w <= 63).
   function automatic logic signed [63:0] saturate_w(input logic signed [63:0] v,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/lbm_moment_sum.sv
// Combinational D2Q9 moment sums (rho, mx, my) with WIDTH+4-bit accumulation and
// saturation back to signed WIDTH.
module lbm_moment_sum
   import lbm_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [NumDirs*WIDTH-1:0] f,
   output logic [WIDTH-1:0]         rho,
   output logic [WIDTH-1:0]         mx,
   output logic [WIDTH-1:0]         my
);

   localparam int unsigned SW = WIDTH + 4;

   logic signed [SW-1:0] fe [NumDirs];
   logic signed [SW-1:0] rho_w;
   logic signed [SW-1:0] mx_w;
   logic signed [SW-1:0] my_w;

   always_comb begin
      for (int i = 0; i < NumDirs; i++) begin
         fe[i] = {{4{f[i*WIDTH+WIDTH-1]}}, f[i*WIDTH +: WIDTH]};
      end
      rho_w = fe[DirRest] + fe[DirE] + fe[DirN] + fe[DirW] + fe[DirS]
            + fe[DirNe] + fe[DirNw] + fe[DirSw] + fe[DirSe];
      mx_w  = fe[DirE] + fe[DirNe] + fe[DirSe] - fe[DirW] - fe[DirNw] - fe[DirSw];
      my_w  = fe[DirN] + fe[DirNe] + fe[DirNw] - fe[DirS] - fe[DirSw] - fe[DirSe];
      rho   = WIDTH'(saturate_w(64'(rho_w), WIDTH));
      mx    = WIDTH'(saturate_w(64'(mx_w), WIDTH));
      my    = WIDTH'(saturate_w(64'(my_w), WIDTH));
   end

endmodule

// File: rtl/lbm_moment_div_ctrl.sv
// D2Q9 moment stage: sums one node, drives ux=mx/rho then uy=my/rho through an external
// start/busy/valid divider. Define LBM_MOM_SAT_EN to saturate faulted quotients instead of 0.
module lbm_moment_div_ctrl
   import lbm_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FBITS = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NumDirs*WIDTH-1:0] f_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         rho_out,
   output logic [WIDTH-1:0]         ux_out,
   output logic [WIDTH-1:0]         uy_out,
   output logic [1:0]               err_out,
   output logic                     div_start,
   output logic [WIDTH-1:0]         div_x,
   output logic [WIDTH-1:0]         div_y,
   input  logic                     div_busy,
   input  logic                     div_valid,
   input  logic                     div_dbz,
   input  logic                     div_ovf,
   input  logic [WIDTH-1:0]         div_q
);

   if (FBITS >= WIDTH) begin : g_fbits_chk
      $error("FBITS must be smaller than WIDTH");
   end

   lbm_state_e               state_q;
   logic [NumDirs*WIDTH-1:0] f_q;
   logic [WIDTH-1:0]         rho_q, ux_q, uy_q, my_q;
   logic [WIDTH-1:0]         div_x_q, div_y_q;
   logic [1:0]               err_q;
   logic                     in_ready_q, out_valid_q, div_start_q;
   logic [WIDTH-1:0]         rho_s, mx_s, my_s;
   logic [WIDTH-1:0]         fault_v;
   logic                     div_done;

   lbm_moment_sum #(
      .WIDTH(WIDTH)
   ) u_sum (
      .f  (f_q),
      .rho(rho_s),
      .mx (mx_s),
      .my (my_s)
   );

   assign div_done = div_valid | div_dbz | div_ovf;

   // Quotient substituted when the divider flags a fault; div_x_q is the live numerator.
   always_comb begin
      fault_v = '0;
`ifdef LBM_MOM_SAT_EN
      if (div_dbz && (div_x_q == '0)) fault_v = '0;
      else if (!div_x_q[WIDTH-1])     fault_v = {1'b0, {(WIDTH-1){1'b1}}};
      else                            fault_v = {1'b1, {(WIDTH-1){1'b0}}};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         f_q         <= '0;
         rho_q       <= '0;
         ux_q        <= '0;
         uy_q        <= '0;
         my_q        <= '0;
         div_x_q     <= '0;
         div_y_q     <= '0;
         err_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         div_start_q <= 1'b0;
      end else begin
         div_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  f_q        <= f_in;
                  err_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= StSum;
               end
            end
            StSum: begin
               rho_q <= rho_s;
               my_q  <= my_s;
               // Hold off while a divider op abandoned by reset is still draining.
               if (!div_busy) begin
                  div_x_q     <= mx_s;
                  div_y_q     <= rho_s;
                  div_start_q <= 1'b1;
                  state_q     <= StXs;
               end
            end
            StXs: state_q <= StXw;
            StXw: begin
               if (div_done) begin
                  ux_q        <= (div_dbz | div_ovf) ? fault_v : div_q;
                  err_q       <= err_q | {div_ovf, div_dbz};
                  div_x_q     <= my_q;
                  div_start_q <= 1'b1;
                  state_q     <= StYs;
               end
            end
            StYs: state_q <= StYw;
            StYw: begin
               if (div_done) begin
                  uy_q        <= (div_dbz | div_ovf) ? fault_v : div_q;
                  err_q       <= err_q | {div_ovf, div_dbz};
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign rho_out   = rho_q;
   assign ux_out    = ux_q;
   assign uy_out    = uy_q;
   assign err_out   = err_q;
   assign div_start = div_start_q;
   assign div_x     = div_x_q;
   assign div_y     = div_y_q;

endmodule

// File: tb/tb_lbm_moment_div_ctrl.sv
// Directed bench for lbm_moment_div_ctrl with a variable-latency behavioural divider.
module tb_lbm_moment_div_ctrl;

   localparam int unsigned W = 32;
`ifdef LBM_MOM_SAT_EN
   localparam logic [31:0] FaultPos = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] FaultPos = 32'h0000_0000;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [8:0][W-1:0] f_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] rho_out, ux_out, uy_out;
   logic [1:0]   err_out;
   logic         div_start;
   logic [W-1:0] div_x, div_y;
   logic         div_busy = 1'b0;
   logic         div_valid = 1'b0;
   logic         div_dbz = 1'b0;
   logic         div_ovf = 1'b0;
   logic [W-1:0] div_q = '0;

   int n_tests = 0;
   int n_fail = 0;
   int lat_cfg = 1;

   always #5 clk = ~clk;

   lbm_moment_div_ctrl #(
      .WIDTH(W),
      .FBITS(24)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .f_in     (f_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .rho_out  (rho_out),
      .ux_out   (ux_out),
      .uy_out   (uy_out),
      .err_out  (err_out),
      .div_start(div_start),
      .div_x    (div_x),
      .div_y    (div_y),
      .div_busy (div_busy),
      .div_valid(div_valid),
      .div_dbz  (div_dbz),
      .div_ovf  (div_ovf),
      .div_q    (div_q)
   );

   // Q8.24 reference divide: returns {ovf, dbz, q}.
   function automatic logic [33:0] div_model(input logic [31:0] x, input logic [31:0] y);
      longint n, d, q;
      n = longint'(signed'(x)) <<< 24;
      d = longint'(signed'(y));
      if (d == 0) return {2'b01, 32'h0};
      q = n / d;
      if (q > 64'sh7FFF_FFFF || q < -64'sh8000_0000) return {2'b10, 32'h0};
      return {2'b00, q[31:0]};
   endfunction

   logic [31:0] m_x = '0, m_y = '0;
   int          m_cnt = 0;
   logic [33:0] m_res;
   assign m_res = div_model(m_x, m_y);

   always @(posedge clk) begin
      div_valid <= 1'b0;
      div_dbz   <= 1'b0;
      div_ovf   <= 1'b0;
      if (div_start) begin
         m_x      <= div_x;
         m_y      <= div_y;
         m_cnt    <= lat_cfg;
         div_busy <= 1'b1;
      end else if (div_busy) begin
         if (m_cnt <= 1) begin
            div_busy  <= 1'b0;
            div_ovf   <= m_res[33];
            div_dbz   <= m_res[32];
            div_valid <= ~(m_res[33] | m_res[32]);
            div_q     <= m_res[31:0];
         end
         m_cnt <= m_cnt - 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_node(input string name, input logic [8:0][W-1:0] f, input int lat,
                           input int stall, input logic [31:0] erho, input logic [31:0] eux,
                           input logic [31:0] euy, input logic [1:0] eerr);
      bit got;
      got = 1'b0;
      lat_cfg = lat;
      @(negedge clk);
      check_eq({name, "_pre_in_ready"}, 64'(in_ready), 64'd1);
      f_in     = f;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_eq({name, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      for (int c = 0; c < 400 && !got; c++) begin
         if (out_valid) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         check_eq({name, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      check_eq({name, "_rho"}, 64'(rho_out), 64'(erho));
      check_eq({name, "_ux"}, 64'(ux_out), 64'(eux));
      check_eq({name, "_uy"}, 64'(uy_out), 64'(euy));
      check_eq({name, "_err"}, 64'(err_out), 64'(eerr));
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check_eq({name, "_stall_hold"}, {out_valid, in_ready, div_start, err_out, ux_out},
                  {1'b1, 1'b0, 1'b0, eerr, eux});
         check_eq({name, "_stall_rho_uy"}, {rho_out, uy_out}, {erho, euy});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_eq({name, "_done"}, {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   initial begin
      logic [8:0][W-1:0] fv;
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", {61'd0, in_ready, out_valid, div_start}, 64'b100);
      check_eq("rst_data", {rho_out, ux_out}, 64'd0);
      check_eq("rst_misc", {uy_out, 30'd0, err_out}, 64'd0);
      check_eq("rst_div", {div_x, div_y}, 64'd0);
      rst = 1'b0;

      fv = '0; fv[0] = 32'h0100_0000;
      run_node("rest", fv, 1, 0, 32'h0100_0000, 32'h0, 32'h0, 2'b00);

      fv = '0; fv[0] = 32'h0080_0000; fv[1] = 32'h0080_0000;
      run_node("east", fv, 3, 5, 32'h0100_0000, 32'h0080_0000, 32'h0, 2'b00);

      fv = '0; fv[0] = 32'hFF00_0000; fv[1] = 32'h0100_0000;
      run_node("dbz", fv, 56, 0, 32'h0, FaultPos, 32'h0, 2'b01);

      fv = '0; fv[0] = 32'h9C80_0000; fv[1] = 32'h6400_0000;
      run_node("ovf", fv, 7, 0, 32'h0080_0000, FaultPos, 32'h0, 2'b10);

      // Positive sums overflow WIDTH and clamp; quotient of clamped values is exactly 1.0.
      fv = '0; fv[0] = 32'h7FFF_FFFF; fv[1] = 32'h7FFF_FFFF; fv[2] = 32'h7FFF_FFFF;
      run_node("satpos", fv, 2, 0, 32'h7FFF_FFFF, 32'h0100_0000, 32'h0100_0000, 2'b00);

      fv = '0; fv[5] = 32'hFF00_0000;
      run_node("ne_neg", fv, 4, 0, 32'hFF00_0000, 32'h0100_0000, 32'h0100_0000, 2'b00);

      // Reset while waiting on the first quotient, then a fresh node.
      lat_cfg = 56;
      @(negedge clk);
      fv = '0; fv[0] = 32'h0100_0000;
      f_in = fv;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("pre_rst_busy", {62'd0, in_ready, div_busy}, 64'b01);
      #2 rst = 1'b1;
      #1 check_eq("rst_async_start", 64'(div_start), 64'd0);
      @(negedge clk);
      check_eq("rst_mid_ctrl", {62'd0, in_ready, out_valid}, 64'b10);
      rst = 1'b0;
      fv = '0; fv[0] = 32'h0080_0000; fv[1] = 32'h0080_0000;
      run_node("post_rst", fv, 4, 0, 32'h0100_0000, 32'h0080_0000, 32'h0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
